mgr_noc_locl_arb: RTL

- Packet-atomic round-robin arbiter in the manager.
- Shares the single local→NoC datapath port (locl__noc__dp_*) between NUM_REQ local requesters, e.g. result writer, config responder and memory-read returner.
- A grant locks at start-of-message and releases after the end-of-message beat is accepted.
- The output is one registered pipeline stage that drives the NoC controller's local input.

---
 rtl/mgr_noc_locl_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mgr_noc_locl_arb.sv
// mgr_noc_locl_arb: packet-atomic round-robin arbiter sharing the
// local->NoC datapath port, with one registered output stage.
module mgr_noc_locl_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNTL_W  = 2,
    parameter int TYPE_W  = 2,
    parameter int PTYPE_W = 2,
    parameter int DTYPE_W = 2,
    parameter int DATA_W  = 64,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic [NUM_REQ-1:0]           req__arb__valid,
    input  logic [NUM_REQ*CNTL_W-1:0]    req__arb__cntl,
    input  logic [NUM_REQ*TYPE_W-1:0]    req__arb__type,
    input  logic [NUM_REQ*PTYPE_W-1:0]   req__arb__ptype,
    input  logic [NUM_REQ*DTYPE_W-1:0]   req__arb__desttype,
    input  logic [NUM_REQ-1:0]           req__arb__pvalid,
    input  logic [NUM_REQ*DATA_W-1:0]    req__arb__data,
    output logic [NUM_REQ-1:0]           arb__req__ready,
    output logic                         locl__noc__dp_valid,
    output logic [CNTL_W-1:0]            locl__noc__dp_cntl,
    output logic [TYPE_W-1:0]            locl__noc__dp_type,
    output logic [PTYPE_W-1:0]           locl__noc__dp_ptype,
    output logic [DTYPE_W-1:0]           locl__noc__dp_desttype,
    output logic                         locl__noc__dp_pvalid,
    output logic [DATA_W-1:0]            locl__noc__dp_data,
    input  logic                         noc__locl__dp_ready,
    output logic [GW-1:0]                arb__cfg__grant_id,
    output logic                         arb__cfg__proto_err
);

    localparam logic [CNTL_W-1:0] C_MOM = CNTL_W'(0);
    localparam logic [CNTL_W-1:0] C_SOM = CNTL_W'(1);
    localparam logic [CNTL_W-1:0] C_EOM = CNTL_W'(2);
    localparam logic [CNTL_W-1:0] C_SE  = CNTL_W'(3);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t               state;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        win;
    logic [GW-1:0]        drn_idx;
    logic                 found;
    logic                 drn_found;
    logic                 err;
    logic                 first;
    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   drn;
    logic                 or_accept;
    logic                 beat_acc;
    logic [CNTL_W-1:0]    g_cntl;
    logic                 g_start;
    logic                 g_end;
    logic [GW-1:0]        rr_next;
    int                   idx;

    // split valid requesters into packet starts and stray mid-packet beats
    always_comb begin
        cand = '0;
        drn  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = req__arb__valid[i] &&
                      (req__arb__cntl[i*CNTL_W +: CNTL_W] == C_SOM ||
                       req__arb__cntl[i*CNTL_W +: CNTL_W] == C_SE);
            drn[i]  = req__arb__valid[i] &&
                      (req__arb__cntl[i*CNTL_W +: CNTL_W] == C_MOM ||
                       req__arb__cntl[i*CNTL_W +: CNTL_W] == C_EOM);
        end
    end

    // round-robin search for a start candidate beginning at rr_ptr
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // lowest-index stray beat, drained when nothing can start
    always_comb begin
        drn_found = 1'b0;
        drn_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!drn_found && drn[i]) begin
                drn_found = 1'b1;
                drn_idx   = GW'(i);
            end
        end
    end

    assign or_accept = !locl__noc__dp_valid || noc__locl__dp_ready;
    assign g_cntl    = req__arb__cntl[grant*CNTL_W +: CNTL_W];
    assign g_start   = (g_cntl == C_SOM) || (g_cntl == C_SE);
    assign g_end     = (g_cntl == C_EOM) || (g_cntl == C_SE);
    assign beat_acc  = (state == S_XFER) && req__arb__valid[grant] && or_accept;
    assign rr_next   = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);

    // ready goes only to the granted requester, or to a drained stray beat
    always_comb begin
        arb__req__ready = '0;
        if (state == S_XFER)
            arb__req__ready[grant] = or_accept;
        else if (!found && drn_found)
            arb__req__ready[drn_idx] = 1'b1;
    end

    // grant FSM: lock on start-of-message, release after end-of-message
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            err    <= 1'b0;
            first  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= win;
                        first <= 1'b1;
                        state <= S_XFER;
                    end else if (drn_found) begin
                        err <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (beat_acc) begin
                        first <= 1'b0;
                        if (g_start && !first)
                            err <= 1'b1;
                        if (g_end) begin
                            rr_ptr <= rr_next;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // output stage: load on accept, hold everything while stalled
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            locl__noc__dp_valid    <= 1'b0;
            locl__noc__dp_cntl     <= '0;
            locl__noc__dp_type     <= '0;
            locl__noc__dp_ptype    <= '0;
            locl__noc__dp_desttype <= '0;
            locl__noc__dp_pvalid   <= 1'b0;
            locl__noc__dp_data     <= '0;
        end else if (or_accept) begin
            locl__noc__dp_valid <= beat_acc;
            if (beat_acc) begin
                locl__noc__dp_cntl     <= g_cntl;
                locl__noc__dp_type     <= req__arb__type[grant*TYPE_W +: TYPE_W];
                locl__noc__dp_ptype    <= req__arb__ptype[grant*PTYPE_W +: PTYPE_W];
                locl__noc__dp_desttype <= req__arb__desttype[grant*DTYPE_W +: DTYPE_W];
                locl__noc__dp_pvalid   <= req__arb__pvalid[grant];
                locl__noc__dp_data     <= req__arb__data[grant*DATA_W +: DATA_W];
            end
        end
    end

    assign arb__cfg__grant_id  = grant;
    assign arb__cfg__proto_err = err;

endmodule
